bpu_resolve_queue: RTL and testbench

Branch-resolution tracker sitting between fetch and execute on the update side of the branch history table. It records every predicted branch at fetch in an in-order queue, retires entries as execute resolves them, and issues the BHT update triple (update_valid/update_pc/update_taken). It also raises a one-cycle redirect to fetch on misprediction and squashes all younger in-flight entries.

---
 rtl/bpu_resolve_queue.sv | 148 ++++++++++++++
 tb/tb_bpu_resolve_queue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bpu_resolve_queue.sv
// Branch-resolution queue: tracks predicted branches in fetch order, retires them as execute
// resolves them, emits BHT update strobes and a redirect on misprediction.
module bpu_resolve_queue #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [31:0]      enq_pc,
  input  logic             enq_pred_taken,
  input  logic [31:0]      enq_pred_target,
  input  logic             res_valid,
  input  logic             res_taken,
  input  logic [31:0]      res_target,
  input  logic             flush,
  output logic             update_valid,
  output logic [31:0]      update_pc,
  output logic             update_taken,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [PTR_W:0]   count,
  output logic             res_err
);

  localparam logic [PTR_W:0]   FullCount = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CntOne    = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PtrOne    = PTR_W'(1);

  logic [31:0] pc_mem     [DEPTH];
  logic        taken_mem  [DEPTH];
  logic [31:0] target_mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             update_valid_q, update_valid_d;
  logic [31:0]      update_pc_q, update_pc_d;
  logic             update_taken_q, update_taken_d;
  logic             redirect_valid_q, redirect_valid_d;
  logic [31:0]      redirect_pc_q, redirect_pc_d;
  logic             res_err_q, res_err_d;

  logic        full, empty, enq_fire, res_fire, mispredict, wr_en;
  logic [31:0] head_pc, head_target;
  logic        head_taken;

  assign full      = (count_q == FullCount);
  assign empty     = (count_q == '0);
  // Gated by rst so nothing is accepted while the queue is being cleared.
  assign enq_ready = !full && !rst;
  assign enq_fire  = enq_valid && enq_ready;
  assign res_fire  = res_valid && !empty;

  assign head_pc     = pc_mem[head_q];
  assign head_taken  = taken_mem[head_q];
  assign head_target = target_mem[head_q];

  assign mispredict = res_fire && ((head_taken != res_taken) ||
                                   (res_taken && (head_target != res_target)));
  // A mispredict squashes everything younger, including a same-cycle enqueue.
  assign wr_en = enq_fire && !flush && !mispredict;

  always_comb begin
    head_d           = head_q;
    tail_d           = tail_q;
    count_d          = count_q;
    update_valid_d   = 1'b0;
    update_pc_d      = update_pc_q;
    update_taken_d   = update_taken_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    res_err_d        = res_err_q;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (res_valid && empty) begin
        res_err_d = 1'b1;
      end
      if (res_fire) begin
        update_valid_d = 1'b1;
        update_pc_d    = head_pc;
        update_taken_d = res_taken;
        head_d         = head_q + PtrOne;
      end
      if (wr_en) begin
        tail_d = tail_q + PtrOne;
      end
      case ({wr_en, res_fire})
        2'b10:   count_d = count_q + CntOne;
        2'b01:   count_d = count_q - CntOne;
        default: count_d = count_q;
      endcase
      if (mispredict) begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = res_taken ? res_target : head_pc + 32'd4;
        head_d           = '0;
        tail_d           = '0;
        count_d          = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      update_valid_q   <= 1'b0;
      update_pc_q      <= '0;
      update_taken_q   <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      res_err_q        <= 1'b0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      update_valid_q   <= update_valid_d;
      update_pc_q      <= update_pc_d;
      update_taken_q   <= update_taken_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      res_err_q        <= res_err_d;
    end
  end

  // Entry storage carries no reset; occupancy is governed by the pointers and count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      pc_mem[tail_q]     <= enq_pc;
      taken_mem[tail_q]  <= enq_pred_taken;
      target_mem[tail_q] <= enq_pred_target;
    end
  end

  assign update_valid   = update_valid_q;
  assign update_pc      = update_pc_q;
  assign update_taken   = update_taken_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign count          = count_q;
  assign res_err        = res_err_q;

endmodule

// File: tb/tb_bpu_resolve_queue.sv
// Directed and randomized checks of bpu_resolve_queue against a queue-based reference model.
module tb_bpu_resolve_queue;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic           clk = 1'b0;
  logic           rst;
  logic           enq_valid;
  logic           enq_ready;
  logic [31:0]    enq_pc;
  logic           enq_pred_taken;
  logic [31:0]    enq_pred_target;
  logic           res_valid;
  logic           res_taken;
  logic [31:0]    res_target;
  logic           flush;
  logic           update_valid;
  logic [31:0]    update_pc;
  logic           update_taken;
  logic           redirect_valid;
  logic [31:0]    redirect_pc;
  logic [PTR_W:0] count;
  logic           res_err;

  always #5 clk = ~clk;

  bpu_resolve_queue #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .enq_valid       (enq_valid),
    .enq_ready       (enq_ready),
    .enq_pc          (enq_pc),
    .enq_pred_taken  (enq_pred_taken),
    .enq_pred_target (enq_pred_target),
    .res_valid       (res_valid),
    .res_taken       (res_taken),
    .res_target      (res_target),
    .flush           (flush),
    .update_valid    (update_valid),
    .update_pc       (update_pc),
    .update_taken    (update_taken),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .count           (count),
    .res_err         (res_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic        pt;
    logic [31:0] tgt;
  } entry_t;

  entry_t      mq[$];
  logic        m_uv, m_ut, m_rv, m_err;
  logic [31:0] m_up, m_rp;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    enq_valid       = 1'b0;
    enq_pc          = '0;
    enq_pred_taken  = 1'b0;
    enq_pred_target = '0;
    res_valid       = 1'b0;
    res_taken       = 1'b0;
    res_target      = '0;
    flush           = 1'b0;
  endtask

  task automatic set_enq(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    enq_valid       = 1'b1;
    enq_pc          = pc;
    enq_pred_taken  = pt;
    enq_pred_target = tgt;
  endtask

  // Resolve the oldest model entry exactly as it was predicted.
  task automatic set_res_correct();
    res_valid  = 1'b1;
    res_taken  = mq[0].pt;
    res_target = mq[0].pt ? mq[0].tgt : $urandom;
  endtask

  task automatic model_step();
    entry_t e;
    bit     ready;
    bit     mis;
    mis = 1'b0;
    if (rst) begin
      mq.delete();
      m_err = 1'b0; m_uv = 1'b0; m_up = '0; m_ut = 1'b0; m_rv = 1'b0; m_rp = '0;
    end else if (flush) begin
      mq.delete();
      m_uv = 1'b0; m_rv = 1'b0;
    end else begin
      ready = (mq.size() < DEPTH);
      m_uv  = 1'b0;
      m_rv  = 1'b0;
      if (res_valid && mq.size() == 0) m_err = 1'b1;
      if (res_valid && mq.size() > 0) begin
        e    = mq.pop_front();
        m_uv = 1'b1;
        m_up = e.pc;
        m_ut = res_taken;
        mis  = (e.pt != res_taken) || (res_taken && e.tgt != res_target);
        if (mis) begin
          m_rv = 1'b1;
          m_rp = res_taken ? res_target : e.pc + 32'd4;
          mq.delete();
        end
      end
      if (enq_valid && ready && !mis) begin
        e.pc = enq_pc; e.pt = enq_pred_taken; e.tgt = enq_pred_target;
        mq.push_back(e);
      end
    end
  endtask

  // Advance one clock: update model, apply the edge, compare all outputs.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("count", 32'(count), 32'(mq.size()));
    check("enq_ready", 32'(enq_ready), 32'(!rst && mq.size() < DEPTH));
    check("update_valid", 32'(update_valid), 32'(m_uv));
    check("redirect_valid", 32'(redirect_valid), 32'(m_rv));
    check("res_err", 32'(res_err), 32'(m_err));
    if (m_uv) begin
      check("update_pc", update_pc, m_up);
      check("update_taken", 32'(update_taken), 32'(m_ut));
    end
    if (m_rv) check("redirect_pc", redirect_pc, m_rp);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    check("rst_enq_ready_low", 32'(enq_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_enq_ready", 32'(enq_ready), 32'd1);
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    tick();
    check("reset_update_pc", update_pc, 32'd0);
    check("reset_redirect_pc", redirect_pc, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_enq_ready", 32'(enq_ready), 32'd1);

    // Correctly predicted taken branch.
    set_enq(32'h1000, 1'b1, 32'h2000);
    tick();
    idle();
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h2000;
    tick();
    idle();
    check("tp1_update_valid", 32'(update_valid), 32'd1);
    check("tp1_update_pc", update_pc, 32'h1000);
    check("tp1_redirect_valid", 32'(redirect_valid), 32'd0);
    check("tp1_count", 32'(count), 32'd0);
    tick();

    // Mispredict on the first of three not-taken predictions.
    for (int i = 0; i < 3; i++) begin
      set_enq(32'h100 + 32'(4 * i), 1'b0, 32'h0);
      tick();
    end
    idle();
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h400;
    tick();
    idle();
    check("tp2_update_pc", update_pc, 32'h100);
    check("tp2_redirect_valid", 32'(redirect_valid), 32'd1);
    check("tp2_redirect_pc", redirect_pc, 32'h400);
    check("tp2_count", 32'(count), 32'd0);
    res_valid = 1'b1; res_taken = 1'b0;
    tick();
    idle();
    check("tp2_res_err", 32'(res_err), 32'd1);
    tick();
    do_reset();

    // Fall-through PC wraps past the top of the address space.
    set_enq(32'hFFFF_FFFC, 1'b1, 32'h2000);
    tick();
    idle();
    res_valid = 1'b1; res_taken = 1'b0;
    tick();
    idle();
    check("tp3_redirect_pc_wrap", redirect_pc, 32'h0);

    // Fill, then resolve while full with an enqueue pending.
    for (int i = 0; i < DEPTH; i++) begin
      set_enq(32'h8000 + 32'(4 * i), 1'(i % 2), 32'h9000 + 32'(i));
      tick();
    end
    idle();
    check("tp4_full_count", 32'(count), 32'(DEPTH));
    check("tp4_full_ready", 32'(enq_ready), 32'd0);
    set_enq(32'hA000, 1'b0, 32'h0);
    set_res_correct();
    tick();
    idle();
    check("tp4_count_after", 32'(count), 32'(DEPTH - 1));
    check("tp4_ready_after", 32'(enq_ready), 32'd1);
    for (int i = 0; i < 20; i++) begin
      set_enq(32'hB000 + 32'(4 * i), 1'($urandom), $urandom);
      set_res_correct();
      tick();
    end
    idle();
    do_reset();

    // Flush beats a same-cycle resolve and enqueue.
    for (int i = 0; i < 4; i++) begin
      set_enq(32'hC000 + 32'(4 * i), 1'b0, 32'h0);
      tick();
    end
    idle();
    flush = 1'b1;
    set_enq(32'hD000, 1'b0, 32'h0);
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h1234;
    tick();
    idle();
    check("tp5_update_valid", 32'(update_valid), 32'd0);
    check("tp5_redirect_valid", 32'(redirect_valid), 32'd0);
    check("tp5_count", 32'(count), 32'd0);

    // Reset overrides a pending mispredict.
    for (int i = 0; i < 5; i++) begin
      set_enq(32'hE000 + 32'(4 * i), 1'b0, 32'h0);
      tick();
    end
    idle();
    rst = 1'b1;
    res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h5555;
    tick();
    idle();
    check("tp6_update_valid", 32'(update_valid), 32'd0);
    check("tp6_update_pc", update_pc, 32'd0);
    check("tp6_update_taken", 32'(update_taken), 32'd0);
    check("tp6_redirect_valid", 32'(redirect_valid), 32'd0);
    check("tp6_redirect_pc", redirect_pc, 32'd0);
    check("tp6_count", 32'(count), 32'd0);
    check("tp6_res_err", 32'(res_err), 32'd0);
    rst = 1'b0;
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      idle();
      if ($urandom_range(0, 3) != 0) set_enq($urandom & 32'hFFFF_FFFC, 1'($urandom), $urandom);
      if (mq.size() > 0 && $urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 3) != 0) begin
          set_res_correct();
        end else begin
          res_valid  = 1'b1;
          res_taken  = 1'($urandom);
          res_target = $urandom;
        end
      end else begin
        res_valid = ($urandom_range(0, 15) == 0);
      end
      flush = ($urandom_range(0, 31) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      tick();
    end
    idle();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
